// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: register index and pipeline control state
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - datapath <-> pipeline controller signal bundle
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    import cpu_types_pkg::*;

    logic             ihit;
    logic             dhit;
    logic             mem_dren;
    logic             mem_dwen;
    logic             mem_redirect;
    logic             ex_memtoReg;
    regbits_t         ex_dest_reg;
    regbits_t         id_rs;
    regbits_t         id_rt;
    logic             id_halt;
    logic             wb_halt;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Datapath side: supplies hazard/status inputs, consumes latch controls.
    modport master (
        output ihit, dhit, mem_dren, mem_dwen, mem_redirect, ex_memtoReg,
               ex_dest_reg, id_rs, id_rt, id_halt, wb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halt, stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, mem_dren, mem_dwen, mem_redirect, ex_memtoReg,
               ex_dest_reg, id_rs, id_rt, id_halt, wb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halt, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - combinational load-use hazard detection between EX and ID
module hazard_unit
    import cpu_types_pkg::*;
(
    input  logic     i_ex_memtoReg,
    input  regbits_t i_ex_dest_reg,
    input  regbits_t i_id_rs,
    input  regbits_t i_id_rt,
    output logic     o_load_use
);

    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign o_load_use = i_ex_memtoReg && (i_ex_dest_reg != '0) &&
                        ((i_ex_dest_reg == i_id_rs) || (i_ex_dest_reg == i_id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer: halt FSM, latch control priority mux, counters
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic CLK,
    input  logic nRST,
    pipeline_ctrl_if.slave bus
);

    ctrl_state_t      r_state;
    ctrl_state_t      w_next_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_load_use;
    logic w_dmem_busy;
    logic w_redirect_acc;
    logic w_pc_en;
    logic w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
    logic w_ifid_flush, w_idex_flush, w_exmem_flush, w_memwb_flush;

    hazard_unit u_hazard (
        .i_ex_memtoReg (bus.ex_memtoReg),
        .i_ex_dest_reg (bus.ex_dest_reg),
        .i_id_rs       (bus.id_rs),
        .i_id_rt       (bus.id_rt),
        .o_load_use    (w_load_use)
    );

    assign w_dmem_busy    = (bus.mem_dren || bus.mem_dwen) && !bus.dhit;
    // A redirect during a data wait is held in MEM and only counted once the access completes.
    assign w_redirect_acc = (r_state != HALTED) && !w_dmem_busy && bus.mem_redirect;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN: begin
                if (bus.wb_halt && w_memwb_en) begin
                    w_next_state = HALTED;
                end else if (bus.id_halt && !w_dmem_busy && !w_load_use) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.wb_halt && w_memwb_en) begin
                    w_next_state = HALTED;
                end else if (w_redirect_acc) begin
                    w_next_state = RUN;
                end
            end
            HALTED:  w_next_state = HALTED;
            default: w_next_state = RUN;
        endcase
    end

    always_comb begin
        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_idex_en     = 1'b1;
        w_exmem_en    = 1'b1;
        w_memwb_en    = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        w_memwb_flush = 1'b0;
        if (r_state == HALTED || w_dmem_busy) begin
            w_pc_en    = 1'b0;
            w_ifid_en  = 1'b0;
            w_idex_en  = 1'b0;
            w_exmem_en = 1'b0;
            w_memwb_en = 1'b0;
        end else if (bus.mem_redirect) begin
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
        end else if (w_load_use) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
        end else if (r_state == DRAIN || !bus.ihit) begin
            w_pc_en      = 1'b0;
            w_ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_en && (r_state != HALTED) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_redirect_acc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_en       = w_pc_en;
    assign bus.ifid_en     = w_ifid_en;
    assign bus.idex_en     = w_idex_en;
    assign bus.exmem_en    = w_exmem_en;
    assign bus.memwb_en    = w_memwb_en;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_flush  = w_idex_flush;
    assign bus.exmem_flush = w_exmem_flush;
    assign bus.memwb_flush = w_memwb_flush;
    assign bus.halt        = (r_state == HALTED);
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic CLK;
    logic nRST;

    pipeline_ctrl_if #(.CNT_W(32)) bus ();

    pipeline_ctrl #(.CNT_W(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, memwb_flush}
    localparam logic [8:0] NORM   = 9'b1_1111_0000;
    localparam logic [8:0] FREEZE = 9'b0_0000_0000;
    localparam logic [8:0] REDIR  = 9'b1_1111_1110;
    localparam logic [8:0] LU     = 9'b0_0111_0100;
    localparam logic [8:0] FETCH  = 9'b0_1111_1000;
    localparam logic [8:0] HALTV  = 9'b0_0000_0000;

    typedef struct packed {
        logic [8:0]  ctl;
        logic [31:0] stall;
        logic [31:0] flsh;
        logic        halt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    task automatic cyc(input logic [8:0] ctl, input int stall, input int flsh, input logic hlt);
        exp_t e;
        exp_t x;
        logic [8:0] got;
        sb.push_back('{ctl: ctl, stall: 32'(stall), flsh: 32'(flsh), halt: hlt});
        @(negedge CLK);
        x = sb.pop_front();
        got = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
               bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush};
        e = x;
        checks++;
        assert (got === e.ctl) else begin
            errors++;
            $error("FAIL ctl step %0d got %b exp %b", step_no, got, e.ctl);
        end
        checks++;
        assert (bus.stall_cnt === e.stall) else begin
            errors++;
            $error("FAIL stall_cnt step %0d got %0d exp %0d", step_no, bus.stall_cnt, e.stall);
        end
        checks++;
        assert (bus.flush_cnt === e.flsh) else begin
            errors++;
            $error("FAIL flush_cnt step %0d got %0d exp %0d", step_no, bus.flush_cnt, e.flsh);
        end
        checks++;
        assert (bus.halt === e.halt) else begin
            errors++;
            $error("FAIL halt step %0d got %b exp %b", step_no, bus.halt, e.halt);
        end
        step_no++;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST             = 1'b0;
        bus.ihit         = 1'b1;
        bus.dhit         = 1'b0;
        bus.mem_dren     = 1'b0;
        bus.mem_dwen     = 1'b0;
        bus.mem_redirect = 1'b0;
        bus.ex_memtoReg  = 1'b0;
        bus.ex_dest_reg  = 5'd0;
        bus.id_rs        = 5'd0;
        bus.id_rt        = 5'd0;
        bus.id_halt      = 1'b0;
        bus.wb_halt      = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;

        cyc(NORM, 0, 0, 1'b0);

        // load-use on rs, one bubble
        bus.ex_memtoReg = 1'b1; bus.ex_dest_reg = 5'd5; bus.id_rs = 5'd5; bus.id_rt = 5'd1;
        cyc(LU, 0, 0, 1'b0);
        bus.ex_memtoReg = 1'b0;
        cyc(NORM, 1, 0, 1'b0);
        // load to r0 never stalls
        bus.ex_memtoReg = 1'b1; bus.ex_dest_reg = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        cyc(NORM, 1, 0, 1'b0);
        // load-use on rt
        bus.ex_dest_reg = 5'd7; bus.id_rs = 5'd3; bus.id_rt = 5'd7;
        cyc(LU, 1, 0, 1'b0);
        bus.ex_memtoReg = 1'b0;
        cyc(NORM, 2, 0, 1'b0);

        // data wait 3 cycles then hit
        bus.mem_dren = 1'b1; bus.dhit = 1'b0;
        cyc(FREEZE, 2, 0, 1'b0);
        cyc(FREEZE, 3, 0, 1'b0);
        cyc(FREEZE, 4, 0, 1'b0);
        bus.dhit = 1'b1;
        cyc(NORM, 5, 0, 1'b0);
        bus.mem_dren = 1'b0; bus.dhit = 1'b0;

        // single redirect
        bus.mem_redirect = 1'b1;
        cyc(REDIR, 5, 0, 1'b0);
        bus.mem_redirect = 1'b0;
        cyc(NORM, 5, 1, 1'b0);

        // redirect held during a write wait counts once on dhit
        bus.mem_dwen = 1'b1; bus.mem_redirect = 1'b1;
        cyc(FREEZE, 5, 1, 1'b0);
        cyc(FREEZE, 6, 1, 1'b0);
        bus.dhit = 1'b1;
        cyc(REDIR, 7, 1, 1'b0);
        bus.mem_dwen = 1'b0; bus.dhit = 1'b0; bus.mem_redirect = 1'b0;
        cyc(NORM, 7, 2, 1'b0);

        // fetch miss
        bus.ihit = 1'b0;
        cyc(FETCH, 7, 2, 1'b0);
        bus.ihit = 1'b1;
        cyc(NORM, 8, 2, 1'b0);

        // redirect outranks load-use
        bus.ex_memtoReg = 1'b1; bus.ex_dest_reg = 5'd5; bus.id_rs = 5'd5; bus.mem_redirect = 1'b1;
        cyc(REDIR, 8, 2, 1'b0);
        bus.ex_memtoReg = 1'b0; bus.mem_redirect = 1'b0;
        cyc(NORM, 8, 3, 1'b0);

        // halt drain then HALTED
        bus.id_halt = 1'b1;
        cyc(NORM, 8, 3, 1'b0);
        bus.id_halt = 1'b0;
        cyc(FETCH, 8, 3, 1'b0);
        cyc(FETCH, 9, 3, 1'b0);
        bus.wb_halt = 1'b1;
        cyc(FETCH, 10, 3, 1'b0);
        bus.wb_halt = 1'b0;
        cyc(HALTV, 11, 3, 1'b1);
        bus.ihit = 1'b0; bus.mem_redirect = 1'b1;
        cyc(HALTV, 11, 3, 1'b1);
        bus.ihit = 1'b1; bus.mem_redirect = 1'b0;

        // reset leaves HALTED
        nRST = 1'b0;
        cyc(HALTV, 11, 3, 1'b1);
        nRST = 1'b1;
        cyc(NORM, 0, 0, 1'b0);

        // DRAIN squashed by redirect returns to RUN
        bus.id_halt = 1'b1;
        cyc(NORM, 0, 0, 1'b0);
        bus.id_halt = 1'b0; bus.mem_redirect = 1'b1;
        cyc(REDIR, 0, 0, 1'b0);
        bus.mem_redirect = 1'b0;
        cyc(NORM, 0, 1, 1'b0);

        // wb_halt with simultaneous redirect: HALTED wins
        bus.wb_halt = 1'b1; bus.mem_redirect = 1'b1;
        cyc(REDIR, 0, 1, 1'b0);
        bus.wb_halt = 1'b0; bus.mem_redirect = 1'b0;
        cyc(HALTV, 0, 2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage pipeline. Each cycle it decides which pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) advance, hold or are zeroed, and whether the PC updates. It handles data-memory wait, fetch miss, load-use hazards, taken-branch/jump redirect and halt drain, and keeps stall and flush counters. It sits beside the latch interfaces in the datapath top and drives their enable/flush inputs.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- nRST  in  1  synchronous reset, active low.
- ihit  in  1  instruction fetch completes this cycle.
- dhit  in  1  data access in MEM completes this cycle.
- mem_dren, mem_dwen  in  1 each  MEM stage requests a data read / write.
- mem_redirect  in  1  branch taken or jump resolved in MEM; PC loads target.
- ex_memtoReg  in  1  instruction in EX is a load.
- ex_dest_reg  in  5 (regbits_t)  destination register of the EX instruction.
- id_rs, id_rt  in  5 each  source registers of the ID instruction.
- id_halt  in  1  HALT decoded in ID.
- wb_halt  in  1  HALT at MEM/WB output.
- pc_en  out  1  PC updates.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch loads its inputs.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch loads zero (bubble); flush overrides en.
- halt  out  1  sticky processor halted.
- stall_cnt  out  CNT_W  cycles with pc_en=0 outside HALTED.
- flush_cnt  out  CNT_W  number of redirect events accepted.

## Operation
- States: RUN, DRAIN, HALTED (ctrl_state_t).
- Defaults: all en=1, all flush=0, pc_en=1.
- Decisions are evaluated in this priority order; the first match wins:
  1. HALTED: all en=0, pc_en=0, halt=1.
  2. dmem_busy = (mem_dren|mem_dwen) & !dhit: all en=0 and pc_en=0, no flush. Freeze the whole pipe.
  3. mem_redirect: ifid_flush, idex_flush and exmem_flush=1, pc_en=1, flush_cnt++.
  4. load_use = ex_memtoReg & ex_dest_reg!=0 & (ex_dest_reg==id_rs | ex_dest_reg==id_rt): pc_en=0, ifid_en=0, idex_flush=1.
  5. DRAIN, or !ihit: pc_en=0, ifid_flush=1.
- Transitions:
  - RUN→DRAIN when id_halt and the pipe advances, i.e. rules 1, 2 and 4 not active.
  - RUN or DRAIN→HALTED when wb_halt & memwb_en.
  - DRAIN→RUN when mem_redirect, because the halt is squashed.
  - HALTED exits only by reset.
- stall_cnt increments when pc_en=0 and state≠HALTED. Both counters saturate at all-ones.

## Timing
- Control outputs are combinational from the registered state and current inputs, with zero-cycle latency. State and counters are registered.
- Reset (nRST low at an edge): state=RUN, halt=0, stall_cnt=0, flush_cnt=0. Reset mid-operation discards DRAIN/HALTED immediately.
- A redirect coinciding with dmem_busy is deferred. The MEM stage holds, so mem_redirect stays asserted until dhit.
- A load-use hazard inserts exactly one bubble. On the next cycle the load is in MEM and rule 4 is false.
- Simultaneous wb_halt and mem_redirect: HALTED wins, because the older instruction commits first.

## Structure
- Add to cpu_types_pkg: ctrl_state_t enum {RUN, DRAIN, HALTED}. regbits_t already exists there.
- One sub-module: hazard_unit (combinational load_use detection), instantiated once.
- Top contains the FSM, the priority mux and the counters.

## Test plan
- Load r5 in EX, ID uses rs=5 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. Repeat with dest r0 → no stall.
- mem_dren=1, dhit=0 for 3 cycles then 1 → all en=0 for 3 cycles, advance on cycle 4; stall_cnt=3.
- mem_redirect for 1 cycle → IF/ID, ID/EX and EX/MEM flushed, pc_en=1, flush_cnt=1. The same event during a dhit wait is counted only once, on the cycle dhit=1.
- id_halt → DRAIN, ifid_flush each cycle. wb_halt 3 cycles later → HALTED, halt=1, all en=0 thereafter.
- HALTED, then nRST low for 1 edge → state RUN, halt=0, counters 0, pc_en=1.
